// File: rtl/piso_shift_ctrl.sv
// Parallel-in serial-out shifter with a load handshake, bit counter and
// selectable bit order. Define PISO_PARITY_EN to append an even-parity bit
// after the data bits of every word.
module piso_shift_ctrl #(
   parameter int unsigned WIDTH = 8,
   // Derived from WIDTH; leave at its default.
   parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             load_ready,
   input  logic             lsb_first,
   input  logic             shift,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
   typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic               order_q, order_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef PISO_PARITY_EN
   logic               parity_q, parity_d;
`endif

   // Next-state logic: load handshake in idle, one bit per enabled edge while shifting.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      order_d     = order_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d    = parity_q;
`endif
      case (state_q)
         StIdle: begin
            if (load) begin
               shreg_d = din;
               order_d = lsb_first;
               cnt_d   = CNT_W'(WIDTH);
               state_d = StShift;
`ifdef PISO_PARITY_EN
               parity_d = ^din;
`endif
            end
         end
         StShift: begin
            if (shift) begin
               out_valid_d = 1'b1;
               cnt_d       = cnt_q - CNT_W'(1);
               if (order_q) begin
                  out_d   = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               end else begin
                  out_d   = shreg_q[WIDTH-1];
                  shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               end
               if (cnt_q == CNT_W'(1)) begin
`ifdef PISO_PARITY_EN
                  state_d = StParity;
`else
                  // Returning to idle here lets a new load transfer on the done cycle.
                  state_d = StIdle;
                  done_d  = 1'b1;
`endif
               end
            end
         end
`ifdef PISO_PARITY_EN
         StParity: begin
            if (shift) begin
               out_d       = parity_q;
               out_valid_d = 1'b1;
               done_d      = 1'b1;
               state_d     = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shreg_q     <= '0;
         order_q     <= 1'b0;
         cnt_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         order_q     <= order_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef PISO_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // Output drive; load_ready is combinational so a load can transfer on the done cycle.
   always_comb begin
      load_ready = (state_q == StIdle);
      out        = out_q;
      out_valid  = out_valid_q;
      busy       = busy_q;
      done       = done_q;
   end

endmodule
